// File: rtl/fabric_edge_if.sv
// fabric_edge_if -- bundle of the scan-control, cell-read and edge-stream
// signals between fabric_edge_engine and its environment.
//   master : engine side (drives busy/done, read requests, edge stream)
//   slave  : environment side (drives start, read responses, edge_ready)
// Parameters must match the engine instance they are attached to.
interface fabric_edge_if #(
  parameter int NUM_CELLS     = 1024,
  parameter int HASH_WIDTH    = 64,
  parameter int MAX_IN_DEGREE = 256
);
  localparam int AW = $clog2(NUM_CELLS);
  localparam int SW = (MAX_IN_DEGREE > 1) ? $clog2(MAX_IN_DEGREE) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  cell_rd_en;
  logic [AW-1:0]         cell_rd_addr;
  logic [HASH_WIDTH-1:0] cell_rd_data;
  logic                  cell_rd_active;
  logic                  edge_valid;
  logic                  edge_ready;
  logic [AW-1:0]         edge_src;
  logic [AW-1:0]         edge_dst;
  logic [SW-1:0]         edge_slot;
  logic [31:0]           edge_count;

  modport master (
    input  start, cell_rd_data, cell_rd_active, edge_ready,
    output busy, done, cell_rd_en, cell_rd_addr,
           edge_valid, edge_src, edge_dst, edge_slot, edge_count
  );

  modport slave (
    output start, cell_rd_data, cell_rd_active, edge_ready,
    input  busy, done, cell_rd_en, cell_rd_addr,
           edge_valid, edge_src, edge_dst, edge_slot, edge_count
  );
endinterface

// File: rtl/fabric_edge_engine.sv
// fabric_edge_engine -- scans every ordered cell pair (i,j), i != j, reads both
// cell registers, and emits an edge i->j when the pair passes the activity,
// overlap, popcount-ordering, hash-threshold and in-degree tests.
// Ports:
//   clk            : rising-edge clock
//   reset          : synchronous active-high reset
//   bus (master)   : start/busy/done, cell read request/response,
//                    edge stream (valid/ready/src/dst/slot), edge_count
// Optional feature: define FABRIC_OUT_DEGREE_LIMIT_EN to cap edges emitted per
// source cell at MAX_OUT_DEGREE (remaining pairs are still scanned).
//
// state | meaning
// IDLE  | waiting for start
// RD_I  | read request for cell i
// CAP_I | capture ri/ai
// RD_J  | read request for cell j (skipped, and j advanced, when j == i)
// CAP_J | capture rj/aj
// EVAL  | evaluate acceptance of pair (i,j)
// EMIT  | present edge, wait for edge_ready
// DONE  | one-cycle done pulse
module fabric_edge_engine #(
  parameter int         NUM_CELLS      = 1024,
  parameter int         HASH_WIDTH     = 64,
  parameter int         MAX_IN_DEGREE  = 256,
  parameter int         MAX_OUT_DEGREE = 64,
  parameter logic [8:0] EDGE_THRESH    = 9'd128
) (
  input logic           clk,
  input logic           reset,
  fabric_edge_if.master bus
);
  localparam int AW = $clog2(NUM_CELLS);
  localparam int SW = (MAX_IN_DEGREE > 1) ? $clog2(MAX_IN_DEGREE) : 1;
  localparam int IW = $clog2(MAX_IN_DEGREE + 1);
  localparam int PW = $clog2(HASH_WIDTH + 1);
  localparam logic [31:0]   NC32  = 32'(NUM_CELLS);
  localparam logic [AW-1:0] LAST  = AW'(NUM_CELLS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_I  = 3'd1;
  localparam logic [2:0] CAP_I = 3'd2;
  localparam logic [2:0] RD_J  = 3'd3;
  localparam logic [2:0] CAP_J = 3'd4;
  localparam logic [2:0] EVAL  = 3'd5;
  localparam logic [2:0] EMIT  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  if (NUM_CELLS < 2 || MAX_IN_DEGREE < 1 || MAX_OUT_DEGREE < 1) begin : g_param_check
    $error("fabric_edge_engine: illegal parameter value");
  end

  function automatic logic [PW-1:0] popcount(input logic [HASH_WIDTH-1:0] v);
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < HASH_WIDTH; b++) cnt = cnt + PW'(v[b]);
    return cnt;
  endfunction

  // 32-bit finaliser-style mix; only the low byte feeds the threshold test.
  function automatic logic [7:0] hash_low(input logic [31:0] seed_in, input logic [31:0] key_in);
    logic [31:0] h;
    h = key_in ^ seed_in;
    h = h ^ (h >> 16);
    h = h * 32'h85eb_ca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2_ae35;
    h = h ^ (h >> 16);
    return h[7:0];
  endfunction

  logic [2:0]            state;
  logic [AW-1:0]         i, j;
  logic [HASH_WIDTH-1:0] ri, rj;
  logic                  ai, aj;
  logic [IW-1:0]         in_deg [NUM_CELLS];
  logic [SW-1:0]         slot;
  logic [31:0]           edge_count;

  logic                  last_i, last_j;
  logic [2:0]            adv_state;
  logic [AW-1:0]         adv_i, adv_j;
  logic [IW-1:0]         deg_j;
  logic [31:0]           seed, key;
  logic [7:0]            hash_lo;
  logic                  out_ok;
  logic                  accept;
  logic                  handshake;

  // Common "move to next pair" step shared by RD_J (diagonal skip), EVAL
  // (reject) and EMIT (handshake).
  always_comb begin
    last_i    = (i == LAST);
    last_j    = (j == LAST);
    adv_j     = last_j ? '0 : j + AW'(1);
    adv_i     = (last_j && !last_i) ? i + AW'(1) : i;
    adv_state = !last_j ? RD_J : (last_i ? DONE : RD_I);
  end

  assign deg_j     = in_deg[j];
  assign seed      = 32'(i) * NC32 + 32'(j);
  assign key       = 32'(ri ^ rj);
  assign hash_lo   = hash_low(seed, key);
  assign handshake = (state == EMIT) && bus.edge_ready;

`ifdef FABRIC_OUT_DEGREE_LIMIT_EN
  localparam int OW = $clog2(MAX_OUT_DEGREE + 1);
  logic [OW-1:0] out_cnt;

  always_ff @(posedge clk) begin
    if (reset)              out_cnt <= '0;
    else if (state == RD_I) out_cnt <= '0;
    else if (handshake)     out_cnt <= out_cnt + OW'(1);
  end

  assign out_ok = (out_cnt < OW'(MAX_OUT_DEGREE));
`else
  assign out_ok = 1'b1;
`endif

  assign accept = ai && aj && (|(ri & rj)) && (popcount(ri) < popcount(rj)) &&
                  ({1'b0, hash_lo} < EDGE_THRESH) && (deg_j < IW'(MAX_IN_DEGREE)) && out_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      ri         <= '0;
      rj         <= '0;
      ai         <= 1'b0;
      aj         <= 1'b0;
      slot       <= '0;
      edge_count <= '0;
      for (int c = 0; c < NUM_CELLS; c++) in_deg[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            edge_count <= '0;
            for (int c = 0; c < NUM_CELLS; c++) in_deg[c] <= '0;
            i     <= '0;
            j     <= '0;
            state <= RD_I;
          end
        end
        RD_I:  state <= CAP_I;
        CAP_I: begin
          ri    <= bus.cell_rd_data;
          ai    <= bus.cell_rd_active;
          state <= RD_J;
        end
        RD_J: begin
          if (j == i) begin
            i     <= adv_i;
            j     <= adv_j;
            state <= adv_state;
          end else begin
            state <= CAP_J;
          end
        end
        CAP_J: begin
          rj    <= bus.cell_rd_data;
          aj    <= bus.cell_rd_active;
          state <= EVAL;
        end
        EVAL: begin
          if (accept) begin
            slot  <= deg_j[SW-1:0];
            state <= EMIT;
          end else begin
            i     <= adv_i;
            j     <= adv_j;
            state <= adv_state;
          end
        end
        EMIT: begin
          if (bus.edge_ready) begin
            in_deg[j] <= deg_j + IW'(1);
            if (edge_count != 32'hFFFF_FFFF) edge_count <= edge_count + 32'd1;
            i     <= adv_i;
            j     <= adv_j;
            state <= adv_state;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cell_rd_en   = 1'b0;
    bus.cell_rd_addr = '0;
    if (state == RD_I) begin
      bus.cell_rd_en   = 1'b1;
      bus.cell_rd_addr = i;
    end else if (state == RD_J && j != i) begin
      bus.cell_rd_en   = 1'b1;
      bus.cell_rd_addr = j;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.edge_valid = (state == EMIT);
  assign bus.edge_src   = (state == EMIT) ? i : '0;
  assign bus.edge_dst   = (state == EMIT) ? j : '0;
  assign bus.edge_slot  = (state == EMIT) ? slot : '0;
  assign bus.edge_count = edge_count;
endmodule

// File: tb/tb_fabric_edge_engine.sv
module tb_fabric_edge_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT 0: threshold 256, out-limit 1; DUT 1: threshold 0;
  // DUT 2: MAX_IN_DEGREE 2; DUT 3: threshold 128 (checked against a hash model)
  fabric_edge_if #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256)) if_a ();
  fabric_edge_if #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256)) if_z ();
  fabric_edge_if #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(2))   if_m ();
  fabric_edge_if #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256)) if_h ();

  fabric_edge_engine #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256), .MAX_OUT_DEGREE(1),
                       .EDGE_THRESH(9'd256)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  fabric_edge_engine #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256), .MAX_OUT_DEGREE(64),
                       .EDGE_THRESH(9'd0))   dut_z (.clk(clk), .reset(reset), .bus(if_z));
  fabric_edge_engine #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(2), .MAX_OUT_DEGREE(64),
                       .EDGE_THRESH(9'd256)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  fabric_edge_engine #(.NUM_CELLS(4), .HASH_WIDTH(8), .MAX_IN_DEGREE(256), .MAX_OUT_DEGREE(64),
                       .EDGE_THRESH(9'd128)) dut_h (.clk(clk), .reset(reset), .bus(if_h));

  logic       start_v [4];
  logic       ready_v [4];
  logic       rd_act_v [4];
  logic [7:0] rd_data_v [4];
  logic       ev [4], busy_v [4], done_v [4], en_v [4];
  logic [7:0] addr_v [4], src_v [4], dst_v [4], slot_v [4];
  logic [31:0] cnt_v [4];

  assign if_a.start = start_v[0]; assign if_a.edge_ready = ready_v[0];
  assign if_a.cell_rd_data = rd_data_v[0]; assign if_a.cell_rd_active = rd_act_v[0];
  assign if_z.start = start_v[1]; assign if_z.edge_ready = ready_v[1];
  assign if_z.cell_rd_data = rd_data_v[1]; assign if_z.cell_rd_active = rd_act_v[1];
  assign if_m.start = start_v[2]; assign if_m.edge_ready = ready_v[2];
  assign if_m.cell_rd_data = rd_data_v[2]; assign if_m.cell_rd_active = rd_act_v[2];
  assign if_h.start = start_v[3]; assign if_h.edge_ready = ready_v[3];
  assign if_h.cell_rd_data = rd_data_v[3]; assign if_h.cell_rd_active = rd_act_v[3];

  assign ev[0] = if_a.edge_valid; assign busy_v[0] = if_a.busy; assign done_v[0] = if_a.done;
  assign en_v[0] = if_a.cell_rd_en; assign addr_v[0] = 8'(if_a.cell_rd_addr); assign cnt_v[0] = if_a.edge_count;
  assign src_v[0] = 8'(if_a.edge_src); assign dst_v[0] = 8'(if_a.edge_dst); assign slot_v[0] = 8'(if_a.edge_slot);
  assign ev[1] = if_z.edge_valid; assign busy_v[1] = if_z.busy; assign done_v[1] = if_z.done;
  assign en_v[1] = if_z.cell_rd_en; assign addr_v[1] = 8'(if_z.cell_rd_addr); assign cnt_v[1] = if_z.edge_count;
  assign src_v[1] = 8'(if_z.edge_src); assign dst_v[1] = 8'(if_z.edge_dst); assign slot_v[1] = 8'(if_z.edge_slot);
  assign ev[2] = if_m.edge_valid; assign busy_v[2] = if_m.busy; assign done_v[2] = if_m.done;
  assign en_v[2] = if_m.cell_rd_en; assign addr_v[2] = 8'(if_m.cell_rd_addr); assign cnt_v[2] = if_m.edge_count;
  assign src_v[2] = 8'(if_m.edge_src); assign dst_v[2] = 8'(if_m.edge_dst); assign slot_v[2] = 8'(if_m.edge_slot);
  assign ev[3] = if_h.edge_valid; assign busy_v[3] = if_h.busy; assign done_v[3] = if_h.done;
  assign en_v[3] = if_h.cell_rd_en; assign addr_v[3] = 8'(if_h.cell_rd_addr); assign cnt_v[3] = if_h.edge_count;
  assign src_v[3] = 8'(if_h.edge_src); assign dst_v[3] = 8'(if_h.edge_dst); assign slot_v[3] = 8'(if_h.edge_slot);

  // shared cell memory, one-cycle read latency per DUT
  logic [7:0] mem [4];
  logic [3:0] act_mask;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (en_v[k]) begin
        rd_data_v[k] <= mem[addr_v[k][1:0]];
        rd_act_v[k]  <= act_mask[addr_v[k][1:0]];
      end
    end
  end

  typedef struct {
    int src;
    int dst;
    int slot;
  } edge_t;

  typedef struct {
    int          dut;
    int          stall;
    logic [31:0] cells;   // {cell3, cell2, cell1, cell0}
    logic [3:0]  act;     // bit c = cell c active
    int          n;       // expected edge count; -1 = use hash model
    int          first;   // index of first expected edge in etab
  } vec_t;

  vec_t  vt [10];
  edge_t etab [$];
  edge_t exp_q [$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic addv(input int idx, input int dut, input int stall, input logic [31:0] cells,
                      input logic [3:0] act, input int n);
    vt[idx] = '{dut: dut, stall: stall, cells: cells, act: act, n: n, first: etab.size()};
  endtask

  task automatic pe(input int s, input int d, input int sl);
    etab.push_back('{src: s, dst: d, slot: sl});
  endtask

  function automatic logic [31:0] fmix(input logic [31:0] seed, input logic [31:0] key);
    logic [31:0] h;
    h = key ^ seed;
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  // Reference scan for 4 cells, 8-bit registers, MAX_IN_DEGREE 256.
  task automatic model_edges(input logic [31:0] cells, input logic [3:0] act, input int thresh);
    int indeg [4];
    logic [7:0] ri, rj;
    logic [31:0] h;
    for (int c = 0; c < 4; c++) indeg[c] = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (a != b) begin
          ri = cells[8*a +: 8];
          rj = cells[8*b +: 8];
          h  = fmix(32'(a * 4 + b), {24'h0, ri ^ rj});
          if (act[a] && act[b] && ((ri & rj) != 0) && ($countones(ri) < $countones(rj)) &&
              (int'(h[7:0]) < thresh) && (indeg[b] < 256)) begin
            exp_q.push_back('{src: a, dst: b, slot: indeg[b]});
            indeg[b]++;
          end
        end
      end
    end
  endtask

  task automatic apply_vec(input int v);
    int k, got, dones, held, cyc;
    logic [7:0] h_src, h_dst, h_slot;
    k = vt[v].dut;
    for (int c = 0; c < 4; c++) mem[c] = vt[v].cells[8*c +: 8];
    act_mask = vt[v].act;
    exp_q.delete();
    if (vt[v].n < 0) model_edges(vt[v].cells, vt[v].act, 128);
    else for (int q = 0; q < vt[v].n; q++) exp_q.push_back(etab[vt[v].first + q]);

    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
    check($sformatf("v%0d_busy_start", v), 32'(busy_v[k]), 1);
    check($sformatf("v%0d_first_rd", v), {23'h0, en_v[k], addr_v[k]}, {23'h0, 1'b1, 8'h00});

    got = 0; dones = 0; held = 0; cyc = 0;
    h_src = '0; h_dst = '0; h_slot = '0;
    while (dones == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done_v[k]) dones++;
      if (ev[k]) begin
        if (held == 0) begin
          h_src = src_v[k]; h_dst = dst_v[k]; h_slot = slot_v[k];
        end else begin
          check($sformatf("v%0d_hold_src", v), 32'(src_v[k]), 32'(h_src));
          check($sformatf("v%0d_hold_dst", v), 32'(dst_v[k]), 32'(h_dst));
          check($sformatf("v%0d_hold_slot", v), 32'(slot_v[k]), 32'(h_slot));
        end
        if (held >= vt[v].stall) begin
          if (got < exp_q.size()) begin
            check($sformatf("v%0d_e%0d_src", v, got), 32'(src_v[k]), 32'(exp_q[got].src));
            check($sformatf("v%0d_e%0d_dst", v, got), 32'(dst_v[k]), 32'(exp_q[got].dst));
            check($sformatf("v%0d_e%0d_slot", v, got), 32'(slot_v[k]), 32'(exp_q[got].slot));
          end else begin
            check($sformatf("v%0d_extra_edge", v), 32'(got + 1), 32'(exp_q.size()));
          end
          got++;
          ready_v[k] = 1'b1;
          held = 0;
        end else begin
          ready_v[k] = 1'b0;
          held++;
        end
      end else begin
        if (held > 0) check($sformatf("v%0d_valid_held", v), 32'(ev[k]), 1);
        held = 0;
        ready_v[k] = 1'b0;
      end
    end
    check($sformatf("v%0d_done_seen", v), 32'(dones), 1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (done_v[k]) dones++;
    end
    check($sformatf("v%0d_done_once", v), 32'(dones), 1);
    check($sformatf("v%0d_edges", v), 32'(got), 32'(exp_q.size()));
    check($sformatf("v%0d_edge_count", v), cnt_v[k], 32'(exp_q.size()));
    check($sformatf("v%0d_busy_end", v), 32'(busy_v[k]), 0);
  endtask

  task automatic wait_ev0(input string name);
    int cyc;
    cyc = 0;
    while (!ev[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(ev[0]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0;
      ready_v[k] = 1'b0;
    end
    for (int c = 0; c < 4; c++) mem[c] = 8'h00;
    act_mask = 4'h0;

    addv(0, 0, 0, 32'h0000_0301, 4'b0011, 1); pe(0, 1, 0);
    addv(1, 1, 0, 32'h010F_0703, 4'hF, 0);
    addv(2, 2, 0, 32'h0F01_0101, 4'hF, 2); pe(0, 3, 0); pe(1, 3, 1);
`ifdef FABRIC_OUT_DEGREE_LIMIT_EN
    addv(3, 0, 0, 32'h0303_0301, 4'hF, 1); pe(0, 1, 0);
`else
    addv(3, 0, 0, 32'h0303_0301, 4'hF, 3); pe(0, 1, 0); pe(0, 2, 0); pe(0, 3, 0);
`endif
    addv(4, 0, 10, 32'h0000_0301, 4'b0011, 1); pe(0, 1, 0);
`ifdef FABRIC_OUT_DEGREE_LIMIT_EN
    addv(5, 0, 0, 32'h0F07_0301, 4'hF, 3); pe(0, 1, 0); pe(1, 2, 0); pe(2, 3, 0);
    addv(6, 0, 0, 32'h0F07_0301, 4'b1011, 2); pe(0, 1, 0); pe(1, 3, 0);
`else
    addv(5, 0, 0, 32'h0F07_0301, 4'hF, 6);
    pe(0, 1, 0); pe(0, 2, 0); pe(0, 3, 0); pe(1, 2, 1); pe(1, 3, 1); pe(2, 3, 2);
    addv(6, 0, 0, 32'h0F07_0301, 4'b1011, 3); pe(0, 1, 0); pe(0, 3, 0); pe(1, 3, 1);
`endif
    addv(7, 0, 0, 32'h0806_0201, 4'hF, 1); pe(1, 2, 0);
    addv(8, 3, 0, 32'h0F07_0301, 4'hF, -1);
    addv(9, 0, 0, 32'h0F01_0101, 4'hF, 3); pe(0, 3, 0); pe(1, 3, 1); pe(2, 3, 2);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d_busy", k), 32'(busy_v[k]), 0);
      check($sformatf("rst%0d_done", k), 32'(done_v[k]), 0);
      check($sformatf("rst%0d_valid", k), 32'(ev[k]), 0);
      check($sformatf("rst%0d_rd_en", k), 32'(en_v[k]), 0);
      check($sformatf("rst%0d_count", k), cnt_v[k], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) apply_vec(v);

    // reset while the second edge of a scan is held in EMIT
    for (int c = 0; c < 4; c++) mem[c] = vt[9].cells[8*c +: 8];
    act_mask = vt[9].act;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_ev0("mid_wait_e0");
    check("mid_e0_src", 32'(src_v[0]), 0);
    check("mid_e0_dst", 32'(dst_v[0]), 3);
    ready_v[0] = 1'b1;
    @(negedge clk); ready_v[0] = 1'b0;
    check("mid_count_1", cnt_v[0], 1);
    wait_ev0("mid_wait_e1");
    check("mid_e1_src", 32'(src_v[0]), 1);
    check("mid_e1_slot", 32'(slot_v[0]), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(ev[0]), 0);
    check("mid_rst_busy", 32'(busy_v[0]), 0);
    check("mid_rst_done", 32'(done_v[0]), 0);
    check("mid_rst_count", cnt_v[0], 0);
    check("mid_rst_rd", {23'h0, en_v[0], addr_v[0]}, 0);
    check("mid_rst_fields", {8'h0, src_v[0], dst_v[0], slot_v[0]}, 0);
    reset = 1'b0;
    @(negedge clk);
    apply_vec(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fabric_edge_engine.md
FABRIC_EDGE_ENGINE -- requirements
Module: fabric_edge_engine

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 1024: number of cells scanned; must be at least 2.
REQ-002 SHALL have parameter HASH_WIDTH, default 64: width of each cell register.
REQ-003 SHALL have parameter MAX_IN_DEGREE, default 256: maximum edges accepted per destination cell.
REQ-004 SHALL have parameter MAX_OUT_DEGREE, default 64: maximum edges emitted per source cell; used only when the REQ-027 macro is defined.
REQ-005 SHALL have parameter EDGE_THRESH, default 128, 9-bit: an edge is accepted when hash[7:0] < EDGE_THRESH; 0 means never, 256 means always.
REQ-006 SHALL have clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-007 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have start, input, 1 bit: one-cycle request to begin a full scan.
REQ-009 SHALL have busy, output, 1 bit: high from the first cycle after an accepted start until done.
REQ-010 SHALL have done, output, 1 bit: one-cycle pulse when the scan completes.
REQ-011 SHALL have cell_rd_en, output, 1 bit, and cell_rd_addr, output, clog2(NUM_CELLS) bits: cell read request.
REQ-012 SHALL have cell_rd_data, input, HASH_WIDTH bits, and cell_rd_active, input, 1 bit: read response, valid exactly 1 cycle after cell_rd_en.
REQ-013 SHALL have edge_valid, output, 1 bit; edge_ready, input, 1 bit; edge_src and edge_dst, output, clog2(NUM_CELLS) bits each; edge_slot, output, clog2(MAX_IN_DEGREE) bits: edge stream.
REQ-014 SHALL have edge_count, output, 32 bits: edges emitted in the current or last scan, saturating at 2^32-1.

Function
REQ-015 SHALL implement states IDLE, RD_I, CAP_I, RD_J, CAP_J, EVAL, EMIT and DONE.
REQ-016 SHALL, in IDLE on start, clear all in-degree counters and edge_count, set i=0 and j=0, and go to RD_I; start SHALL be ignored in every other state.
REQ-017 SHALL, in RD_I, assert cell_rd_en with address i; CAP_I SHALL latch ri and ai (the register and active bit of cell i) and go to RD_J.
REQ-018 SHALL, in RD_J with j==i, issue no read and advance j in the same cycle; otherwise it SHALL read address j, and CAP_J SHALL latch rj and aj and then go to EVAL.
REQ-019 SHALL accept pair (i,j) in EVAL only when all of the following hold:
- ai and aj are both set;
- (ri & rj) != 0;
- popcount(ri) < popcount(rj);
- hash[7:0] < EDGE_THRESH;
- in_deg[j] < MAX_IN_DEGREE.
REQ-020 SHALL compute hash as a 32-bit value with every multiply truncated to 32 bits:
- inputs: seed = (i*NUM_CELLS+j)[31:0], key = (ri^rj)[31:0];
- h = key^seed; h ^= h>>16; h *= 0x85ebca6b; h ^= h>>13; h *= 0xc2b2ae35; h ^= h>>16.
REQ-021 SHALL, on an accepted pair, go to EMIT presenting edge_src=i, edge_dst=j and edge_slot=in_deg[j].
REQ-022 SHALL hold edge_valid and all edge_* fields stable until edge_ready is high; on the handshake cycle it SHALL increment in_deg[j] and edge_count and advance.
REQ-023 SHALL advance by incrementing j; on j wrap it SHALL set j=0, increment i and go to RD_I; after pair (NUM_CELLS-1, NUM_CELLS-1) it SHALL go to DONE.
REQ-024 SHALL, in DONE, pulse done for exactly one cycle, return to IDLE and retain edge_count.
REQ-025 SHALL, when in_deg[j]==MAX_IN_DEGREE, reject the pair silently with no edge and no counter wrap.

Reset
REQ-026 SHALL, while reset is high in any state including mid-EMIT, force:
- state to IDLE;
- busy, done, edge_valid and cell_rd_en to 0;
- edge_count, all in-degree counters, edge_src, edge_dst, edge_slot and cell_rd_addr to 0.

Configuration
REQ-027 SHALL, with macro FABRIC_OUT_DEGREE_LIMIT_EN defined, keep a per-source counter cleared at each RD_I and add the condition out_cnt < MAX_OUT_DEGREE to REQ-019; once the limit is reached, the remaining pairs for that i SHALL still be scanned but all rejected.
REQ-028 SHALL, without FABRIC_OUT_DEGREE_LIMIT_EN, have no out-degree counter and leave MAX_OUT_DEGREE unused.

Verification (NUM_CELLS=4, HASH_WIDTH=8, EDGE_THRESH=256 unless stated)
REQ-029 SHALL cover: cell0=0x01 and cell1=0x03, both active, others inactive -> exactly one edge (0,1) with slot 0, edge_count=1, done pulses once.
REQ-030 SHALL cover: EDGE_THRESH=0, all cells active with overlapping registers -> no edge_valid, edge_count=0, done pulses.
REQ-031 SHALL cover: MAX_IN_DEGREE=2, cells0..2=0x01 and cell3=0x0F, all active -> edges to dst 3 from src 0 and 1 only, slots 0 then 1; src 2 rejected.
REQ-032 SHALL cover: edge_ready held low 10 cycles during EMIT -> edge_valid and all edge fields stable throughout; exactly one edge counted.
REQ-033 SHALL cover: reset asserted during EMIT -> next cycle edge_valid=0, busy=0, edge_count=0; a subsequent start rescans from (0,0).
REQ-034 SHALL cover: with FABRIC_OUT_DEGREE_LIMIT_EN and MAX_OUT_DEGREE=1, cell0=0x01 and cells1..3=0x03 -> src 0 emits only edge (0,1).
